// File: rtl/text_line_writer_if.sv
// Command handshake between the keypad/keyboard decoder and the text line writer.
interface text_line_writer_if #(
  parameter int CODE_W = 6
);
  logic              in_valid;
  logic [1:0]        in_cmd;
  logic [CODE_W-1:0] in_code;
  logic              in_ready;

  modport master (output in_valid, output in_cmd, output in_code, input in_ready);
  modport slave  (input in_valid, input in_cmd, input in_code, output in_ready);
endinterface

// File: rtl/text_line_writer.sv
// Editable working line fed by PUT/BACKSPACE/CLEAR commands; the display copy
// is refreshed only on frame_sync so the monitor never shows a half-edited line.
module text_line_writer #(
  parameter int                N_CHARS = 10,
  parameter int                CODE_W  = 6,
  parameter logic [CODE_W-1:0] BLANK   = 6'd63,
  parameter bit                SCROLL  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  text_line_writer_if.slave           bus,
  input  logic                        frame_sync,
  output logic [N_CHARS*CODE_W-1:0]   text_buffer_in_line,
  output logic [$clog2(N_CHARS+1)-1:0] cursor,
  output logic                        line_full,
  output logic                        overflow
);
  localparam int CUR_W  = $clog2(N_CHARS + 1);
  localparam int LINE_W = N_CHARS * CODE_W;

  localparam logic [1:0] CMD_PUT   = 2'b00;
  localparam logic [1:0] CMD_BKSP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  typedef enum logic {S_IDLE, S_CLR} state_t;

  state_t            state, state_nxt;
  logic [CODE_W-1:0] slots     [N_CHARS];
  logic [CODE_W-1:0] slots_nxt [N_CHARS];
  logic [CUR_W-1:0]  cur_q, cur_nxt, clr_idx, clr_nxt;
  logic              rdy_q, dirty_q, ovf_q, full_q;
  logic              edit, ovf_nxt, accept;
  logic [LINE_W-1:0] line_w, line_q;

  assign accept              = bus.in_valid && rdy_q;
  assign bus.in_ready        = rdy_q;
  assign text_buffer_in_line = line_q;
  assign cursor              = cur_q;
  assign line_full           = full_q;
  assign overflow            = ovf_q;

  always_comb begin
    line_w = '0;
    for (int i = 0; i < N_CHARS; i++) line_w[i*CODE_W +: CODE_W] = slots[i];
  end

  always_comb begin
    state_nxt = state;
    slots_nxt = slots;
    cur_nxt   = cur_q;
    clr_nxt   = clr_idx;
    edit      = 1'b0;
    ovf_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.in_cmd)
            CMD_PUT: begin
              if (cur_q < CUR_W'(N_CHARS)) begin
                slots_nxt[cur_q] = bus.in_code;
                cur_nxt          = cur_q + 1'b1;
                edit             = 1'b1;
              end else if (SCROLL) begin
                for (int i = 0; i < N_CHARS - 1; i++) slots_nxt[i] = slots[i+1];
                slots_nxt[N_CHARS-1] = bus.in_code;
                edit                 = 1'b1;
              end else begin
                ovf_nxt = 1'b1;
              end
            end
            CMD_BKSP: begin
              if (cur_q != '0) begin
                slots_nxt[cur_q - 1'b1] = BLANK;
                cur_nxt                 = cur_q - 1'b1;
                edit                    = 1'b1;
              end
            end
            CMD_CLEAR: begin
              state_nxt = S_CLR;
              clr_nxt   = '0;
              edit      = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_CLR: begin
        // One slot per cycle keeps the clear path to a single write port.
        slots_nxt[clr_idx] = BLANK;
        clr_nxt            = clr_idx + 1'b1;
        if (clr_idx == CUR_W'(N_CHARS - 1)) begin
          cur_nxt   = '0;
          edit      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cur_q   <= '0;
      clr_idx <= '0;
      rdy_q   <= 1'b0;
      dirty_q <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      line_q  <= {N_CHARS{BLANK}};
      for (int i = 0; i < N_CHARS; i++) slots[i] <= BLANK;
    end else begin
      state   <= state_nxt;
      cur_q   <= cur_nxt;
      clr_idx <= clr_nxt;
      rdy_q   <= (state_nxt == S_IDLE);
      ovf_q   <= ovf_nxt;
      full_q  <= (cur_nxt == CUR_W'(N_CHARS));
      slots   <= slots_nxt;
      // An edit on the publish edge must survive so it reaches the next frame.
      if (edit)            dirty_q <= 1'b1;
      else if (frame_sync) dirty_q <= 1'b0;
      if (frame_sync && dirty_q) line_q <= line_w;
    end
  end
endmodule

// File: tb/tb_text_line_writer.sv
// Bench for text_line_writer: both SCROLL variants driven in parallel against a line model.
module tb_text_line_writer;
  localparam int N = 10;
  localparam logic [1:0] PUT = 2'b00, BKSP = 2'b01, CLR = 2'b10, NOP = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic frame_sync;
  logic [59:0] line_o [2];
  logic [3:0]  cur_o  [2];
  logic        full_o [2];
  logic        ovf_o  [2];
  logic        rdy_o  [2];

  text_line_writer_if b0 ();
  text_line_writer_if b1 ();
  assign rdy_o[0] = b0.in_ready;
  assign rdy_o[1] = b1.in_ready;

  text_line_writer #(.SCROLL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .frame_sync(frame_sync),
    .text_buffer_in_line(line_o[0]), .cursor(cur_o[0]), .line_full(full_o[0]), .overflow(ovf_o[0]));
  text_line_writer #(.SCROLL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .frame_sync(frame_sync),
    .text_buffer_in_line(line_o[1]), .cursor(cur_o[1]), .line_full(full_o[1]), .overflow(ovf_o[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference: visible text as a length plus slot contents; index 0/1 = SCROLL 0/1.
  int unsigned m_ln  [2][N];
  int unsigned m_pub [2][N];
  int          m_len [2];
  int          m_clr [2];
  bit          m_dirty [2];
  bit          m_rdy [2];
  bit          m_ovf [2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) begin m_ln[s][i] = 63; m_pub[s][i] = 63; end
      m_len[s] = 0; m_clr[s] = 0; m_dirty[s] = 0; m_rdy[s] = 0; m_ovf[s] = 0;
    end
  endtask

  task automatic model_edge(input bit v, input logic [1:0] c, input int code, input bit fs);
    for (int s = 0; s < 2; s++) begin
      m_ovf[s] = 0;
      if (fs && m_dirty[s]) begin
        for (int i = 0; i < N; i++) m_pub[s][i] = m_ln[s][i];
        m_dirty[s] = 0;
      end
      if (m_clr[s] > 0) begin
        m_ln[s][N - m_clr[s]] = 63;
        m_clr[s]--;
        if (m_clr[s] == 0) begin m_len[s] = 0; m_dirty[s] = 1; end
      end else if (v && m_rdy[s]) begin
        case (c)
          PUT: begin
            if (m_len[s] < N) begin
              m_ln[s][m_len[s]] = code; m_len[s]++; m_dirty[s] = 1;
            end else if (s == 1) begin
              for (int i = 0; i < N - 1; i++) m_ln[s][i] = m_ln[s][i+1];
              m_ln[s][N-1] = code; m_dirty[s] = 1;
            end else m_ovf[s] = 1;
          end
          BKSP: if (m_len[s] > 0) begin m_len[s]--; m_ln[s][m_len[s]] = 63; m_dirty[s] = 1; end
          CLR:  begin m_clr[s] = N; m_dirty[s] = 1; end
          default: ;
        endcase
      end
      m_rdy[s] = (m_clr[s] == 0);
    end
  endtask

  function automatic logic [59:0] exp_line(input int s);
    logic [59:0] r;
    for (int i = 0; i < N; i++) r[i*6 +: 6] = 6'(m_pub[s][i]);
    return r;
  endfunction

  task automatic drive(input bit v, input logic [1:0] c, input logic [5:0] code, input bit fs);
    b0.in_valid = v; b0.in_cmd = c; b0.in_code = code;
    b1.in_valid = v; b1.in_cmd = c; b1.in_code = code;
    frame_sync = fs;
  endtask

  task automatic step(input bit v, input logic [1:0] c, input logic [5:0] code, input bit fs);
    drive(v, c, code, fs);
    @(posedge clk);
    model_edge(v, c, int'(code), fs);
    @(negedge clk);
    drive(1'b0, NOP, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, NOP, 6'd0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, NOP, 6'd0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (line_o[s] !== '1) begin n_err++; $display("FAIL reset_line[%0d]: got %h want all 63", s, line_o[s]); end
      n_cmp++; if (cur_o[s] !== 4'd0) begin n_err++; $display("FAIL reset_cursor[%0d]: got %0d want 0", s, cur_o[s]); end
      n_cmp++; if (ovf_o[s] !== 1'b0 || full_o[s] !== 1'b0) begin n_err++; $display("FAIL reset_flags[%0d]: ovf %b full %b want 0 0", s, ovf_o[s], full_o[s]); end
    end
    rst_n = 1'b1;
    step(1'b0, NOP, 6'd0, 1'b0);
    n_cmp++; if (rdy_o[0] !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy_o[0]); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, PUT, 6'd1, 1'b0);
    step(1'b1, PUT, 6'd2, 1'b0);
    step(1'b1, PUT, 6'd3, 1'b0);
    n_cmp++; if (line_o[0] !== '1) begin n_err++; $display("FAIL basic_prepub: got %h want all 63", line_o[0]); end
    step(1'b0, NOP, 6'd0, 1'b1);
    n_cmp++; if (line_o[0] !== {{7{6'd63}}, 6'd3, 6'd2, 6'd1}) begin n_err++; $display("FAIL basic_line: got %h", line_o[0]); end
    n_cmp++; if (cur_o[0] !== 4'd3) begin n_err++; $display("FAIL basic_cursor: got %0d want 3", cur_o[0]); end
  endtask

  task automatic test_overflow();
    logic [59:0] e0, e1;
    do_reset();
    for (int k = 0; k <= 10; k++) step(1'b1, PUT, 6'(k), 1'b0);
    n_cmp++; if (ovf_o[0] !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", ovf_o[0]); end
    n_cmp++; if (ovf_o[1] !== 1'b0) begin n_err++; $display("FAIL ovf_scroll: got %b want 0", ovf_o[1]); end
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (cur_o[s] !== 4'd10 || full_o[s] !== 1'b1) begin n_err++; $display("FAIL ovf_full[%0d]: cursor %0d full %b want 10 1", s, cur_o[s], full_o[s]); end
    end
    step(1'b0, NOP, 6'd0, 1'b0);
    n_cmp++; if (ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL ovf_width: got %b want 0", ovf_o[0]); end
    step(1'b0, NOP, 6'd0, 1'b1);
    for (int i = 0; i < N; i++) begin e0[i*6 +: 6] = 6'(i); e1[i*6 +: 6] = 6'(i + 1); end
    n_cmp++; if (line_o[0] !== e0) begin n_err++; $display("FAIL ovf_line: got %h want %h", line_o[0], e0); end
    n_cmp++; if (line_o[1] !== e1) begin n_err++; $display("FAIL scroll_line: got %h want %h", line_o[1], e1); end
  endtask

  task automatic test_backspace();
    do_reset();
    step(1'b1, BKSP, 6'd0, 1'b0);
    step(1'b0, NOP, 6'd0, 1'b1);
    n_cmp++; if (cur_o[0] !== 4'd0 || line_o[0] !== '1) begin n_err++; $display("FAIL bksp_zero: cursor %0d line %h", cur_o[0], line_o[0]); end
    step(1'b1, PUT, 6'd1, 1'b0);
    step(1'b1, PUT, 6'd2, 1'b0);
    step(1'b1, PUT, 6'd3, 1'b0);
    step(1'b1, BKSP, 6'd0, 1'b0);
    step(1'b0, NOP, 6'd0, 1'b1);
    n_cmp++; if (cur_o[0] !== 4'd2) begin n_err++; $display("FAIL bksp_cursor: got %0d want 2", cur_o[0]); end
    n_cmp++; if (line_o[0] !== {{8{6'd63}}, 6'd2, 6'd1}) begin n_err++; $display("FAIL bksp_line: got %h", line_o[0]); end
  endtask

  task automatic test_clear();
    int cnt = 0;
    step(1'b1, CLR, 6'd0, 1'b0);
    while (rdy_o[0] === 1'b0 && cnt < 20) begin
      step(1'b1, PUT, 6'd5, 1'b0);
      cnt++;
    end
    n_cmp++; if (cnt != 10) begin n_err++; $display("FAIL clear_busy: ready low %0d cycles want 10", cnt); end
    step(1'b0, NOP, 6'd0, 1'b1);
    n_cmp++; if (line_o[0] !== '1 || cur_o[0] !== 4'd0) begin n_err++; $display("FAIL clear_line: line %h cursor %0d want all 63, 0", line_o[0], cur_o[0]); end
  endtask

  task automatic test_collision();
    do_reset();
    step(1'b1, PUT, 6'd4, 1'b0);
    step(1'b0, NOP, 6'd0, 1'b1);
    step(1'b1, PUT, 6'd9, 1'b1);
    n_cmp++; if (line_o[0] !== {{9{6'd63}}, 6'd4}) begin n_err++; $display("FAIL coll_first: got %h", line_o[0]); end
    step(1'b0, NOP, 6'd0, 1'b1);
    n_cmp++; if (line_o[0] !== {{8{6'd63}}, 6'd9, 6'd4}) begin n_err++; $display("FAIL coll_second: got %h", line_o[0]); end
  endtask

  task automatic test_reset_mid_clr();
    step(1'b1, CLR, 6'd0, 1'b0);
    repeat (3) step(1'b0, NOP, 6'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (line_o[0] !== '1 || line_o[1] !== '1) begin n_err++; $display("FAIL rst_midclr_line: got %h / %h want all 63", line_o[0], line_o[1]); end
    n_cmp++; if (cur_o[0] !== 4'd0 || rdy_o[0] !== 1'b0) begin n_err++; $display("FAIL rst_midclr_ctrl: cursor %0d ready %b want 0 0", cur_o[0], rdy_o[0]); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, NOP, 6'd0, 1'b0);
  endtask

  task automatic test_random();
    bit v, fs;
    logic [1:0] c;
    int r;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      r  = $urandom_range(0, 9);
      c  = (r < 6) ? PUT : (r < 8) ? BKSP : (r == 8) ? NOP : (($urandom_range(0, 3) == 0) ? CLR : PUT);
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 5) == 0);
      step(v, c, 6'($urandom_range(0, 63)), fs);
      for (int s = 0; s < 2; s++) begin
        n_cmp++; if (line_o[s] !== exp_line(s)) begin n_err++; $display("FAIL rnd_line[%0d] cyc %0d: got %h want %h", s, cyc, line_o[s], exp_line(s)); end
        n_cmp++; if (cur_o[s] !== 4'(m_len[s])) begin n_err++; $display("FAIL rnd_cursor[%0d] cyc %0d: got %0d want %0d", s, cyc, cur_o[s], m_len[s]); end
        n_cmp++; if (full_o[s] !== (m_len[s] == N)) begin n_err++; $display("FAIL rnd_full[%0d] cyc %0d: got %b", s, cyc, full_o[s]); end
        n_cmp++; if (ovf_o[s] !== m_ovf[s]) begin n_err++; $display("FAIL rnd_ovf[%0d] cyc %0d: got %b want %b", s, cyc, ovf_o[s], m_ovf[s]); end
        n_cmp++; if (rdy_o[s] !== m_rdy[s]) begin n_err++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b want %b", s, cyc, rdy_o[s], m_rdy[s]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, NOP, 6'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_backspace();
    test_clear();
    test_collision();
    test_reset_mid_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
